// File: rtl/moa_pkg.sv
// -----------------------------------------------------------------------------
// moa_pkg
//   Shared definitions for the multi-operand adder stream (moa_stream).
//   Contents:
//     moa_state_e : FSM state encoding (IDLE, ACC, DONE)
//     clog2()     : constant ceil(log2(n)), used to size the sum and the
//                   operand counter at elaboration time
// -----------------------------------------------------------------------------
package moa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } moa_state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/moa_add.sv
// -----------------------------------------------------------------------------
// moa_add
//   Combinational SUM_W-bit unsigned adder. The WIDTH-bit operand is
//   zero-extended to SUM_W bits before the add, so the result never wraps
//   as long as SUM_W is large enough for the running total.
//   Ports:
//     i_a   [SUM_W-1:0] : running total (or zero for the first operand)
//     i_b   [WIDTH-1:0] : new unsigned operand
//     o_sum [SUM_W-1:0] : i_a + zext(i_b)
// -----------------------------------------------------------------------------
module moa_add #(
  parameter int WIDTH = 4,
  parameter int SUM_W = 6
) (
  input  logic [SUM_W-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [SUM_W-1:0] o_sum
);

  logic [SUM_W-1:0] w_b_ext;

  assign w_b_ext = {{(SUM_W - WIDTH){1'b0}}, i_b};
  assign o_sum   = i_a + w_b_ext;

endmodule

// File: rtl/moa_stream.sv
// -----------------------------------------------------------------------------
// moa_stream
//   Streaming multi-operand adder: accepts NUM_OPS unsigned WIDTH-bit operands
//   over a valid/ready input and presents their exact SUM_W-bit sum over a
//   valid/ready output.
//
//   Handshake: a transfer happens on a rising clk edge where valid && ready.
//   A producer holds valid/data until the transfer; ready may depend on the
//   other side's signals combinationally (in DONE, in_ready == out_ready so a
//   new first operand enters in the same cycle the result leaves).
//
//   Optional feature: define MOA_STREAM_OVF_EN to add out_ovf, which flags
//   (with out_valid) a sum that does not fit in WIDTH bits.
//
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     clr               : synchronous abort of the partial sum / pending result
//     in_valid/in_ready : operand handshake, in_data [WIDTH-1:0]
//     out_valid/out_ready : result handshake, out_sum [SUM_W-1:0]
//     out_ovf           : sum >= 2**WIDTH (only with MOA_STREAM_OVF_EN)
//     dbg_state [1:0]   : current FSM state (moa_state_e encoding)
// -----------------------------------------------------------------------------
module moa_stream
  import moa_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr,
  input  logic                                 in_valid,
  input  logic [WIDTH-1:0]                     in_data,
  output logic                                 in_ready,
  output logic                                 out_valid,
  output logic [WIDTH+clog2(NUM_OPS)-1:0]      out_sum,
  input  logic                                 out_ready,
`ifdef MOA_STREAM_OVF_EN
  output logic                                 out_ovf,
`endif
  output logic [1:0]                           dbg_state
);

  localparam int SUM_W = WIDTH + clog2(NUM_OPS);
  localparam int CNT_W = clog2(NUM_OPS + 1);

  moa_state_e       r_state;
  moa_state_e       w_state_nxt;
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rdy_en;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_last_op;
  logic [SUM_W-1:0] w_add_a;
  logic [SUM_W-1:0] w_sum;

  // r_rdy_en holds in_ready low while in reset and releases it on the first
  // clock edge afterwards, independently of the IDLE state encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  // Ready depends only on state, clr and out_ready (never on in_valid).
  assign w_in_ready = r_rdy_en && !clr && ((r_state != S_DONE) || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_last_op  = (r_cnt == CNT_W'(NUM_OPS - 1));

  // Only ACC adds to the running total; IDLE and DONE start a fresh sum, so
  // the adder's other input is zero there and the operand loads directly.
  assign w_add_a = (r_state == S_ACC) ? r_acc : '0;

  moa_add #(
    .WIDTH (WIDTH),
    .SUM_W (SUM_W)
  ) u_add (
    .i_a   (w_add_a),
    .i_b   (in_data),
    .o_sum (w_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = w_sum;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = S_ACC;
        end
      end

      S_ACC: begin
        if (w_accept) begin
          w_acc_nxt = w_sum;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_last_op) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          if (w_accept) begin
            // Result leaves and the next sum's first operand enters together.
            w_acc_nxt   = w_sum;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = S_ACC;
          end else begin
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // clr overrides every handshake, including a pending result.
    if (clr) begin
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = S_IDLE;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == S_DONE);
  assign out_sum   = (r_state == S_DONE) ? r_acc : '0;
  assign dbg_state = r_state;

`ifdef MOA_STREAM_OVF_EN
  // Any bit above the operand width set means the sum exceeds WIDTH bits.
  assign out_ovf = (r_state == S_DONE) && (|r_acc[SUM_W-1:WIDTH]);
`endif

endmodule

// File: tb/tb_moa_stream.sv
module tb_moa_stream;

  localparam int W      = 4;
  localparam int N      = 4;
  localparam int SW     = 6;
  localparam int W8     = 8;
  localparam int N8     = 3;
  localparam int SW8    = 10;
  localparam int TMO    = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (WIDTH=4, NUM_OPS=4) ----------------
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [SW-1:0] out_sum;
  logic          out_ready = 1'b1;
  logic [1:0]    dbg_state;
`ifdef MOA_STREAM_OVF_EN
  logic          out_ovf;
`endif

  moa_stream #(.WIDTH(W), .NUM_OPS(N)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ready (out_ready),
`ifdef MOA_STREAM_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- DUT (WIDTH=8, NUM_OPS=3) ----------------
  logic           clr8 = 1'b0;
  logic           in_valid8 = 1'b0;
  logic [W8-1:0]  in_data8 = '0;
  logic           in_ready8;
  logic           out_valid8;
  logic [SW8-1:0] out_sum8;
  logic           out_ready8 = 1'b1;
  logic [1:0]     dbg_state8;
`ifdef MOA_STREAM_OVF_EN
  logic           out_ovf8;
`endif

  moa_stream #(.WIDTH(W8), .NUM_OPS(N8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr8),
    .in_valid  (in_valid8),
    .in_data   (in_data8),
    .in_ready  (in_ready8),
    .out_valid (out_valid8),
    .out_sum   (out_sum8),
    .out_ready (out_ready8),
`ifdef MOA_STREAM_OVF_EN
    .out_ovf   (out_ovf8),
`endif
    .dbg_state (dbg_state8)
  );

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [SW:0] exp_q[$];   // {ovf, sum}
  int m_acc = 0;
  int m_cnt = 0;
  logic rnd_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model of one accepted operand; pushes the sum after N operands.
  task automatic model_accept(input int data);
    m_acc = m_acc + data;
    m_cnt = m_cnt + 1;
    if (m_cnt == N) begin
      exp_q.push_back({(m_acc >= (1 << W)) ? 1'b1 : 1'b0, SW'(m_acc)});
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // Result monitor: a result transfers on the edge after a negedge where
  // out_valid && out_ready are both high.
  initial begin
    logic [SW:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got sum %0d, expected no output (t=%0t)", out_sum, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_sum", 32'(out_sum), 32'(e[SW-1:0]));
`ifdef MOA_STREAM_OVF_EN
          check("sb_ovf", 32'(out_ovf), 32'(e[SW]));
`endif
        end
      end
    end
  end

  // Random out_ready during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_phase) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one operand and hold it until accepted; returns at posedge+1.
  task automatic send_op(input logic [W-1:0] data);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = data;
    @(negedge clk);
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected acceptance", n);
    end else begin
      model_accept(int'(data));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [W8-1:0] data);
    in_valid8 = 1'b1;
    in_data8  = data;
    @(negedge clk);
    check("w8_in_ready", 32'(in_ready8), 32'd1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0]  op0, op1, op2, op3;
    logic [SW-1:0] exp_sum;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;

    vecs[0] = '{4'd3,  4'd5,  4'd7,  4'd9,  6'd24, 1'b1};
    vecs[1] = '{4'd15, 4'd15, 4'd15, 4'd15, 6'd60, 1'b1};
    vecs[2] = '{4'd1,  4'd2,  4'd3,  4'd4,  6'd10, 1'b0};
    vecs[3] = '{4'd0,  4'd0,  4'd0,  4'd0,  6'd0,  1'b0};
    vecs[4] = '{4'd15, 4'd0,  4'd0,  4'd1,  6'd16, 1'b1};
    vecs[5] = '{4'd8,  4'd4,  4'd2,  4'd1,  6'd15, 1'b0};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_rel_in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_rel_in_ready_after_edge", 32'(in_ready), 32'd1);
    check("rst_state_idle", 32'(dbg_state), 32'd0);

    // ---- table: back-to-back sums, result one cycle after 4th accept ----
    for (int i = 0; i < 6; i++) begin
      send_op(vecs[i].op0);
      send_op(vecs[i].op1);
      send_op(vecs[i].op2);
      check("vec_not_valid_in_acc", 32'(out_valid), 32'd0);
      send_op(vecs[i].op3);
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_out_sum", 32'(out_sum), 32'(vecs[i].exp_sum));
`ifdef MOA_STREAM_OVF_EN
      check("vec_out_ovf", 32'(out_ovf), 32'(vecs[i].exp_ovf));
`endif
    end
    @(posedge clk);
    #1;
    check("vec_done_to_idle", 32'(dbg_state), 32'd0);
    check("idle_out_sum_zero", 32'(out_sum), 32'd0);

    // ---- back-pressure in DONE ----
    out_ready = 1'b0;
    send_op(4'd2);
    send_op(4'd4);
    send_op(4'd6);
    send_op(4'd8);
    in_valid = 1'b1;
    in_data  = 4'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum_stable", 32'(out_sum), 32'd20);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_same_cycle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(5);
    check("bp_next_in_acc", 32'(dbg_state), 32'd1);
    check("bp_out_valid_cleared", 32'(out_valid), 32'd0);
    send_op(4'd1);
    send_op(4'd1);
    send_op(4'd1);
    check("bp_follow_sum", 32'(out_sum), 32'd8);

    // ---- random gaps and random out_ready, 100 sums ----
    rnd_phase = 1'b1;
    for (int s = 0; s < 100 * N; s++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_op(W'($urandom_range(0, 15)));
    end
    rnd_phase = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("rand_drain_empty", 32'(exp_q.size()), 32'd0);

    // ---- clr after 2 operands ----
    send_op(4'd9);
    send_op(4'd9);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd7;
    @(negedge clk);
    check("clr_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check("clr_state_idle", 32'(dbg_state), 32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    send_op(4'd1);
    send_op(4'd1);
    send_op(4'd1);
    send_op(4'd1);
    check("clr_new_sum", 32'(out_sum), 32'd4);
    @(posedge clk);
    #1;

    // ---- clr drops a pending result ----
    out_ready = 1'b0;
    send_op(4'd3);
    send_op(4'd3);
    send_op(4'd3);
    send_op(4'd3);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_clear();
    check("clr_drops_result", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // ---- async reset in DONE ----
    out_ready = 1'b0;
    send_op(4'd2);
    send_op(4'd2);
    send_op(4'd2);
    send_op(4'd2);
    check("rstd_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstd_async_out_valid", 32'(out_valid), 32'd0);
    check("rstd_async_out_sum", 32'(out_sum), 32'd0);
    check("rstd_async_in_ready", 32'(in_ready), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstd_no_result", 32'(out_valid), 32'd0);
    send_op(4'd6);
    send_op(4'd7);
    send_op(4'd8);
    send_op(4'd9);
    check("rstd_recover_sum", 32'(out_sum), 32'd30);
    @(posedge clk);
    #1;

    // ---- WIDTH=8, NUM_OPS=3 ----
    send8(8'd255);
    send8(8'd255);
    send8(8'd255);
    check("w8_out_valid", 32'(out_valid8), 32'd1);
    check("w8_out_sum_765", 32'(out_sum8), 32'd765);
`ifdef MOA_STREAM_OVF_EN
    check("w8_out_ovf", 32'(out_ovf8), 32'd1);
`endif
    send8(8'd1);
    send8(8'd2);
    send8(8'd3);
    check("w8_out_sum_6", 32'(out_sum8), 32'd6);
`ifdef MOA_STREAM_OVF_EN
    check("w8_out_ovf_0", 32'(out_ovf8), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
